// File: rtl/adau_spi_slave_if.sv
// rtl/adau_spi_slave_if.sv - pin and fabric-side signal bundle for adau_spi_slave
//
// Purpose: groups the three control-port pins together with the parallel
// word handshake, decoded fields and status pulses.
// Modports:
//   slave  - the receiver: pins and ready in; word, fields and status out
//   master - the driver/consumer side: the mirror image of slave
interface adau_spi_slave_if;
  logic        cclk;
  logic        cdata;
  logic        clatch_n;
  logic [31:0] data_out;
  logic        valid;
  logic        ready;
  logic [6:0]  chip_addr;
  logic        rw;
  logic [15:0] sub_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_err;
  logic        overflow;

  modport slave (
    input  cclk, cdata, clatch_n, ready,
    output data_out, valid, chip_addr, rw, sub_addr, wr_data,
           busy, frame_err, overflow
  );

  modport master (
    output cclk, cdata, clatch_n, ready,
    input  data_out, valid, chip_addr, rw, sub_addr, wr_data,
           busy, frame_err, overflow
  );
endinterface

// File: rtl/adau_spi_slave.sv
// rtl/adau_spi_slave.sv - codec control-port SPI receiver with valid/ready output
//
// Purpose: synchronises cclk/cdata/clatch_n, shifts 32-bit MSB-first frames
// on cclk rises inside a clatch_n low window, and hands good frames to the
// fabric through a single-entry valid/ready register.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - adau_spi_slave_if.slave: pins, word/handshake, fields, status
module adau_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  adau_spi_slave_if.slave   bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cclk_sync_q;
  logic [SYNC_STAGES-1:0] cdata_sync_q;
  logic [SYNC_STAGES-1:0] clatch_sync_q;
  logic                   cclk_prev_q;
  logic                   clatch_prev_q;

  logic cclk_s, cdata_s, clatch_s;
  logic cclk_rise, clatch_fall, clatch_rise;

  state_t      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;
  logic        good;

  // Synchronisers reset to the pins' idle levels so an idle release is edge-free.
  // cdata has no previous flop: only its level is ever used, and its equal
  // depth keeps it aligned with cclk.
  always_ff @(posedge clk) begin
    if (reset) begin
      cclk_sync_q   <= '1;
      cdata_sync_q  <= '0;
      clatch_sync_q <= '1;
      cclk_prev_q   <= 1'b1;
      clatch_prev_q <= 1'b1;
    end else begin
      cclk_sync_q   <= {cclk_sync_q[SYNC_STAGES-2:0], bus.cclk};
      cdata_sync_q  <= {cdata_sync_q[SYNC_STAGES-2:0], bus.cdata};
      clatch_sync_q <= {clatch_sync_q[SYNC_STAGES-2:0], bus.clatch_n};
      cclk_prev_q   <= cclk_sync_q[SYNC_STAGES-1];
      clatch_prev_q <= clatch_sync_q[SYNC_STAGES-1];
    end
  end

  assign cclk_s      = cclk_sync_q[SYNC_STAGES-1];
  assign cdata_s     = cdata_sync_q[SYNC_STAGES-1];
  assign clatch_s    = clatch_sync_q[SYNC_STAGES-1];
  assign cclk_rise   = cclk_s & ~cclk_prev_q;
  assign clatch_fall = ~clatch_s & clatch_prev_q;
  assign clatch_rise = clatch_s & ~clatch_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovf_d    = 1'b0;
    good     = 1'b0;

    case (state_q)
      IDLE: begin
        if (clatch_fall) begin
          shreg_d  = '0;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cclk_rise) begin
          shreg_d = {shreg_q[30:0], cdata_s};
          // Saturating at 33 keeps any overlong frame distinguishable from 32.
          if (bitcnt_q != 6'd33) begin
            bitcnt_d = bitcnt_q + 6'd1;
          end
        end
        // Evaluated on the updated count so a final rise coincident with the
        // latch rise still counts toward the frame.
        if (clatch_rise) begin
          state_d = IDLE;
          if (bitcnt_d == 6'd32) begin
            good = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume in the same cycle frees the slot for the incoming word.
    if (good) begin
      if (!valid_q || bus.ready) begin
        data_d  = shreg_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.chip_addr = data_q[31:25];
  assign bus.rw        = data_q[24];
  assign bus.sub_addr  = data_q[23:8];
  assign bus.wr_data   = data_q[7:0];
  assign bus.busy      = (state_q == SHIFT);
  assign bus.frame_err = ferr_q;
  assign bus.overflow  = ovf_q;

endmodule
